// File: rtl/pkt_pkg.sv
// Shared types and limits for the packet byte/word blocks.
package pkt_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FILL     = 2'd1,
        EOP_PEND = 2'd2
    } b2w_state_t;

    localparam int PKT_MAX_BYTES = 8;

endpackage

// File: rtl/pkt_bytes_to_words_n_if.sv
// Word-side packet stream: data beats and a separate eop beat under one valid/ready pair.
// PKT_B2W_KEEP_EN adds a per-lane keep vector.
interface pkt_bytes_to_words_n_if #(
    parameter int BYTES = 4,
    parameter int CW    = 12
) ();
    logic [8*BYTES-1:0] data;
    logic [CW-1:0]      bytecount;
    logic               valid;
    logic               eop;
    logic               err;
    logic               ready;
`ifdef PKT_B2W_KEEP_EN
    logic [BYTES-1:0]   keep;
`endif

    modport master (
`ifdef PKT_B2W_KEEP_EN
        output keep,
`endif
        output data, bytecount, valid, eop, err,
        input  ready
    );

    modport slave (
`ifdef PKT_B2W_KEEP_EN
        input  keep,
`endif
        input  data, bytecount, valid, eop, err,
        output ready
    );
endinterface

// File: rtl/pkt_out_slot.sv
// Single-entry valid/ready holding register; loads and drains in the same cycle when ready=1.
// free tells the producer a load this cycle will not overwrite an unaccepted beat.
module pkt_out_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         load_valid,
    input  logic         load_eop,
    input  logic [W-1:0] load_payload,
    input  logic         ready,
    output logic         valid,
    output logic         eop,
    output logic [W-1:0] payload,
    output logic         free
);

    assign free = !(valid || eop) || ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid   <= 1'b0;
            eop     <= 1'b0;
            payload <= '0;
        end else if (load) begin
            valid   <= load_valid;
            eop     <= load_eop;
            payload <= load_payload;
        end else if (ready) begin
            // Clear on drain so idle outputs read as zero.
            valid   <= 1'b0;
            eop     <= 1'b0;
            payload <= '0;
        end
    end

endmodule

// File: rtl/pkt_bytes_to_words_n.sv
// Packs an eop-framed byte stream into BYTES-wide words with running count, then a separate eop beat.
// Optional keep output under PKT_B2W_KEEP_EN.
module pkt_bytes_to_words_n
    import pkt_pkg::*;
#(
    parameter int BYTES     = 4,
    parameter int CW        = 12,
    parameter int MSB_FIRST = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rxdata,
    input  logic       rxvalid,
    input  logic       rxeop,
    output logic       rxready,
    pkt_bytes_to_words_n_if.master words
);

    localparam int W  = 8 * BYTES;
    localparam int LW = $clog2(BYTES);
`ifdef PKT_B2W_KEEP_EN
    localparam int PW = W + CW + 1 + BYTES;
`else
    localparam int PW = W + CW + 1;
`endif
    localparam logic [1:0]    ST_IDLE  = IDLE;
    localparam logic [1:0]    ST_FILL  = FILL;
    localparam logic [1:0]    ST_PEND  = EOP_PEND;
    localparam logic [CW-1:0] CNT_MAX  = '1;

    generate
        if (BYTES < 2 || BYTES > PKT_MAX_BYTES || CW < 8 || CW > 16) begin : g_bad_param
            $error("pkt_bytes_to_words_n: BYTES must be 2..8 and CW 8..16");
        end
    endgenerate

    logic [1:0]    state;
    logic [W-1:0]  asm_word;
    logic [LW-1:0] lane;
    logic [CW-1:0] count;
    logic          ovf;

    logic          in_idle, in_fill, in_pend;
    logic [LW-1:0] cur_lane;
    int            pos;
    logic          completes;
    logic [W-1:0]  word_nxt;
    logic [CW-1:0] count_nxt;
    logic          ovf_nxt;
    logic          slot_free, acc_byte, acc_eop;
    logic          load, load_valid, load_eop, load_err;
    logic [W-1:0]  load_data;
    logic [CW-1:0] load_cnt;
    logic [PW-1:0] load_pl, slot_pl;
`ifdef PKT_B2W_KEEP_EN
    logic [BYTES-1:0] asm_keep, keep_nxt, load_keep;
`endif

    always_comb begin
        in_idle   = (state == ST_IDLE);
        in_fill   = (state == ST_FILL);
        in_pend   = (state == ST_PEND);
        cur_lane  = in_idle ? '0 : lane;
        completes = (cur_lane == LW'(BYTES - 1));
        pos       = (MSB_FIRST != 0) ? (BYTES - 1 - int'(cur_lane)) : int'(cur_lane);
        word_nxt  = (in_idle ? '0 : asm_word) | (W'(rxdata) << (8 * pos));
`ifdef PKT_B2W_KEEP_EN
        keep_nxt  = (in_idle ? '0 : asm_keep) | (BYTES'(1) << pos);
`endif
        // Saturating count; the byte that would exceed CNT_MAX raises the sticky flag.
        count_nxt = in_idle ? CW'(1) : ((count == CNT_MAX) ? count : count + CW'(1));
        ovf_nxt   = !in_idle && (ovf || (count == CNT_MAX));

        rxready   = rst_n && !in_pend &&
                    !(((rxvalid && completes) || (rxeop && in_fill)) && !slot_free);
        acc_byte  = rxvalid && rxready;
        acc_eop   = rxeop && rxready;

        load       = 1'b0;
        load_valid = 1'b0;
        load_eop   = 1'b0;
        load_err   = 1'b0;
        load_data  = '0;
        load_cnt   = '0;
`ifdef PKT_B2W_KEEP_EN
        load_keep  = '0;
`endif
        if (acc_byte && completes) begin
            load       = 1'b1;
            load_valid = 1'b1;
            load_data  = word_nxt;
            load_cnt   = count_nxt;
`ifdef PKT_B2W_KEEP_EN
            load_keep  = keep_nxt;
`endif
        end else if (acc_eop && in_fill && (lane != '0)) begin
            load       = 1'b1;
            load_valid = 1'b1;
            load_data  = asm_word;
            load_cnt   = count;
`ifdef PKT_B2W_KEEP_EN
            load_keep  = asm_keep;
`endif
        end else if ((acc_eop && in_fill) || (in_pend && slot_free)) begin
            load       = 1'b1;
            load_eop   = 1'b1;
            load_err   = ovf;
            load_cnt   = count;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            asm_word <= '0;
            lane     <= '0;
            count    <= '0;
            ovf      <= 1'b0;
`ifdef PKT_B2W_KEEP_EN
            asm_keep <= '0;
`endif
        end else if (acc_byte) begin
            state    <= ST_FILL;
            lane     <= completes ? '0 : cur_lane + LW'(1);
            asm_word <= completes ? '0 : word_nxt;
            count    <= count_nxt;
            ovf      <= ovf_nxt;
`ifdef PKT_B2W_KEEP_EN
            asm_keep <= completes ? '0 : keep_nxt;
`endif
        end else if (acc_eop && in_fill) begin
            asm_word <= '0;
            lane     <= '0;
`ifdef PKT_B2W_KEEP_EN
            asm_keep <= '0;
`endif
            if (lane != '0) begin
                state <= ST_PEND;
            end else begin
                state <= ST_IDLE;
                count <= '0;
                ovf   <= 1'b0;
            end
        end else if (in_pend && slot_free) begin
            state <= ST_IDLE;
            count <= '0;
            ovf   <= 1'b0;
        end
    end

`ifdef PKT_B2W_KEEP_EN
    assign load_pl = {load_data, load_cnt, load_err, load_keep};
    assign {words.data, words.bytecount, words.err, words.keep} = slot_pl;
`else
    assign load_pl = {load_data, load_cnt, load_err};
    assign {words.data, words.bytecount, words.err} = slot_pl;
`endif

    pkt_out_slot #(.W(PW)) u_slot (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (load),
        .load_valid   (load_valid),
        .load_eop     (load_eop),
        .load_payload (load_pl),
        .ready        (words.ready),
        .valid        (words.valid),
        .eop          (words.eop),
        .payload      (slot_pl),
        .free         (slot_free)
    );

endmodule

// File: tb/tb_pkt_bytes_to_words_n.sv
// Bench for pkt_bytes_to_words_n: three configurations, a packet-level scoreboard and directed checks.
module tb_pkt_bytes_to_words_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] rxd [3];
    logic [2:0] rxv, rxe, rdy;
    wire  [2:0] rxr;

    pkt_bytes_to_words_n_if #(.BYTES(4), .CW(12)) ifa ();
    pkt_bytes_to_words_n_if #(.BYTES(2), .CW(12)) ifb ();
    pkt_bytes_to_words_n_if #(.BYTES(4), .CW(8))  ifc ();

    pkt_bytes_to_words_n #(.BYTES(4), .CW(12), .MSB_FIRST(0)) u_a (
        .clk(clk), .rst_n(rst_n), .rxdata(rxd[0]), .rxvalid(rxv[0]), .rxeop(rxe[0]),
        .rxready(rxr[0]), .words(ifa));
    pkt_bytes_to_words_n #(.BYTES(2), .CW(12), .MSB_FIRST(1)) u_b (
        .clk(clk), .rst_n(rst_n), .rxdata(rxd[1]), .rxvalid(rxv[1]), .rxeop(rxe[1]),
        .rxready(rxr[1]), .words(ifb));
    pkt_bytes_to_words_n #(.BYTES(4), .CW(8), .MSB_FIRST(0)) u_c (
        .clk(clk), .rst_n(rst_n), .rxdata(rxd[2]), .rxvalid(rxv[2]), .rxeop(rxe[2]),
        .rxready(rxr[2]), .words(ifc));

    assign ifa.ready = rdy[0];
    assign ifb.ready = rdy[1];
    assign ifc.ready = rdy[2];

    wire [63:0] o_data [3];
    wire [15:0] o_cnt  [3];
    wire [2:0]  o_vld, o_eop, o_err;
    assign o_data[0] = 64'(ifa.data);
    assign o_data[1] = 64'(ifb.data);
    assign o_data[2] = 64'(ifc.data);
    assign o_cnt[0]  = 16'(ifa.bytecount);
    assign o_cnt[1]  = 16'(ifb.bytecount);
    assign o_cnt[2]  = 16'(ifc.bytecount);
    assign o_vld = {ifc.valid, ifb.valid, ifa.valid};
    assign o_eop = {ifc.eop, ifb.eop, ifa.eop};
    assign o_err = {ifc.err, ifb.err, ifa.err};
`ifdef PKT_B2W_KEEP_EN
    wire [7:0] o_keep [3];
    assign o_keep[0] = 8'(ifa.keep);
    assign o_keep[1] = 8'(ifb.keep);
    assign o_keep[2] = 8'(ifc.keep);
`endif

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Configuration of each instance, as the model sees it.
    function automatic int pb(input int d);
        return (d == 1) ? 2 : 4;
    endfunction
    function automatic bit pm(input int d);
        return (d == 1);
    endfunction
    function automatic int cmax(input int d);
        return (d == 2) ? 255 : 4095;
    endfunction

    typedef struct packed {
        logic        is_eop;
        logic [63:0] data;
        logic [15:0] cnt;
        logic        err;
        logic [7:0]  keep;
    } beat_t;

    beat_t      q [3][64];
    int         wr [3] = '{0, 0, 0};
    int         rd [3] = '{0, 0, 0};
    int         m_n [3] = '{0, 0, 0};
    int         m_lane [3] = '{0, 0, 0};
    logic [63:0] m_word [3];
    logic [7:0]  m_keep [3];

    task automatic push(input int d, input bit is_eop);
        beat_t b;
        b.is_eop = is_eop;
        b.data   = is_eop ? 64'd0 : m_word[d];
        b.cnt    = 16'((m_n[d] > cmax(d)) ? cmax(d) : m_n[d]);
        b.err    = is_eop && (m_n[d] > cmax(d));
        b.keep   = is_eop ? 8'd0 : m_keep[d];
        q[d][wr[d] % 64] = b;
        wr[d]++;
    endtask

    // Each negedge: check visible beats against the expected queue, then fold in the
    // transfers that the coming posedge will perform (inputs are stable until then).
    task automatic monitor();
        bit prev_rst = 1'b0;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (prev_rst) begin
                    chk($sformatf("reset_flags_d%0d", d), {o_vld[d], o_eop[d], o_err[d]}, 0);
                    chk($sformatf("reset_data_d%0d", d), o_data[d], 0);
                    chk($sformatf("reset_count_d%0d", d), o_cnt[d], 0);
`ifdef PKT_B2W_KEEP_EN
                    chk($sformatf("reset_keep_d%0d", d), o_keep[d], 0);
`endif
                end
                if (!rst_n) begin
                    chk($sformatf("reset_rxready_d%0d", d), rxr[d], 0);
                    rd[d] = wr[d];
                    m_n[d] = 0;
                    m_lane[d] = 0;
                end else if (!prev_rst) begin
                    if (o_vld[d] || o_eop[d]) begin
                        if (rd[d] == wr[d]) begin
                            chk($sformatf("unexpected_beat_d%0d", d), {o_vld[d], o_eop[d]}, 0);
                        end else begin
                            beat_t e;
                            e = q[d][rd[d] % 64];
                            chk($sformatf("beat_kind_d%0d", d), {o_vld[d], o_eop[d]},
                                e.is_eop ? 2'b01 : 2'b10);
                            if (!e.is_eop) begin
                                chk($sformatf("beat_data_d%0d", d), o_data[d], e.data);
                                chk($sformatf("beat_count_d%0d", d), o_cnt[d], e.cnt);
                            end else begin
                                chk($sformatf("eop_err_d%0d", d), o_err[d], e.err);
                            end
`ifdef PKT_B2W_KEEP_EN
                            chk($sformatf("beat_keep_d%0d", d), o_keep[d], e.keep);
`endif
                            if (rdy[d]) rd[d]++;
                        end
                    end
                    if (rxv[d] && rxr[d]) begin
                        int pos;
                        pos = pm(d) ? (pb(d) - 1 - m_lane[d]) : m_lane[d];
                        if (m_lane[d] == 0) begin
                            m_word[d] = 64'd0;
                            m_keep[d] = 8'd0;
                        end
                        m_word[d] = m_word[d] | (64'(rxd[d]) << (8 * pos));
                        m_keep[d] = m_keep[d] | (8'd1 << pos);
                        m_n[d]++;
                        m_lane[d]++;
                        if (m_lane[d] == pb(d)) begin
                            push(d, 1'b0);
                            m_lane[d] = 0;
                        end
                    end else if (rxe[d] && rxr[d] && m_n[d] > 0) begin
                        if (m_lane[d] > 0) push(d, 1'b0);
                        push(d, 1'b1);
                        m_n[d] = 0;
                        m_lane[d] = 0;
                    end
                end
            end
            prev_rst = !rst_n;
        end
    endtask

    task automatic offer(input int d, input logic [7:0] b, input bit e);
        rxd[d] = b;
        rxv[d] = !e;
        rxe[d] = e;
    endtask

    task automatic wait_acc(input int d);
        bit ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = rxr[d];
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout_d%0d: rxready never rose, required 1", d);
        end
        rxv[d] = 1'b0;
        rxe[d] = 1'b0;
    endtask

    task automatic send(input int d, input logic [7:0] b, input bit e);
        offer(d, b, e);
        wait_acc(d);
    endtask

    task automatic realign();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_eop(input int d);
        bit got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = o_eop[d];
        end
        if (!got) begin
            n_checks++;
            n_errors++;
            $display("FAIL eop_timeout_d%0d: eop not seen, required 1", d);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        rxv = '0;
        rxe = '0;
        rdy = 3'b111;
        for (int d = 0; d < 3; d++) rxd[d] = 8'h00;
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        realign();

        // Six bytes, ready high: full word one cycle after byte 04, then partial, then eop.
        for (int i = 1; i <= 4; i++) send(0, 8'(i), 1'b0);
        @(negedge clk);
        chk("t1_w0_valid", o_vld[0], 1);
        chk("t1_w0_data", o_data[0], 64'h04030201);
        chk("t1_w0_count", o_cnt[0], 4);
        realign();
        send(0, 8'h05, 1'b0);
        send(0, 8'h06, 1'b0);
        send(0, 8'h00, 1'b1);
        @(negedge clk);
        chk("t1_w1_data", o_data[0], 64'h00000605);
        chk("t1_w1_count", o_cnt[0], 6);
        @(negedge clk);
        chk("t1_eop_kind", {o_vld[0], o_eop[0]}, 2'b01);
        chk("t1_eop_err", o_err[0], 0);
        realign();

        // eop with no bytes is swallowed.
        send(0, 8'h00, 1'b1);
        @(negedge clk);
        chk("idle_eop_no_beat", {o_vld[0], o_eop[0]}, 0);
        realign();

        // Exactly two words: eop follows rxeop directly, no padded beat.
        for (int i = 0; i < 8; i++) send(0, 8'(8'h10 + i), 1'b0);
        send(0, 8'h00, 1'b1);
        @(negedge clk);
        chk("t2_eop_direct", {o_vld[0], o_eop[0]}, 2'b01);
        realign();

        // MSB-first, two lanes.
        send(1, 8'hAA, 1'b0);
        send(1, 8'hBB, 1'b0);
        @(negedge clk);
        chk("t3_w0_data", o_data[1], 64'hAABB);
        chk("t3_w0_count", o_cnt[1], 2);
`ifdef PKT_B2W_KEEP_EN
        chk("t3_w0_keep", o_keep[1], 8'b11);
`endif
        realign();
        send(1, 8'hCC, 1'b0);
        send(1, 8'h00, 1'b1);
        @(negedge clk);
        chk("t3_w1_data", o_data[1], 64'hCC00);
        chk("t3_w1_count", o_cnt[1], 3);
`ifdef PKT_B2W_KEEP_EN
        chk("t3_w1_keep", o_keep[1], 8'b10);
`endif
        @(negedge clk);
        chk("t3_eop_kind", {o_vld[1], o_eop[1]}, 2'b01);
        realign();

        // Backpressure: the byte completing the second word must wait for the slot.
        rdy[0] = 1'b0;
        for (int i = 1; i <= 7; i++) send(0, 8'(8'h20 + i), 1'b0);
        offer(0, 8'h28, 1'b0);
        @(negedge clk);
        chk("t4_rxready_low", rxr[0], 0);
        chk("t4_hold_data", o_data[0], 64'h24232221);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t4_hold_stable", {o_vld[0], o_data[0][31:0], o_cnt[0]}, {1'b1, 32'h24232221, 16'd4});
        end
        realign();
        rdy[0] = 1'b1;
        wait_acc(0);
        send(0, 8'h00, 1'b1);
        realign();

        // Count saturation at 255 with CW=8; err clears for the next packet.
        for (int i = 0; i < 300; i++) send(2, 8'(i), 1'b0);
        @(negedge clk);
        chk("t5_sat_count", o_cnt[2], 255);
        chk("t5_last_data", o_data[2], 64'h2B2A2928);
        realign();
        send(2, 8'h00, 1'b1);
        wait_eop(2);
        chk("t5_err_set", o_err[2], 1);
        realign();
        send(2, 8'h55, 1'b0);
        send(2, 8'h66, 1'b0);
        send(2, 8'h00, 1'b1);
        wait_eop(2);
        chk("t5_err_clear", o_err[2], 0);
        realign();

        // Reset mid-word discards the partial packet entirely.
        send(0, 8'h99, 1'b0);
        send(0, 8'h98, 1'b0);
        rst_n = 1'b0;
        realign();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_no_stale_beat", {o_vld[0], o_eop[0]}, 0);
        realign();
        send(0, 8'h11, 1'b0);
        send(0, 8'h22, 1'b0);
        send(0, 8'h33, 1'b0);
        send(0, 8'h44, 1'b0);
        @(negedge clk);
        chk("t6_data", o_data[0], 64'h44332211);
        chk("t6_count", o_cnt[0], 4);
        realign();
        send(0, 8'h00, 1'b1);
        wait_eop(0);
        chk("t6_eop_err", o_err[0], 0);

        repeat (10) @(posedge clk);
        for (int d = 0; d < 3; d++) chk($sformatf("drain_d%0d", d), 64'(wr[d] - rd[d]), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pkt_bytes_to_words_n.md
# pkt_bytes_to_words_n

Parametrised packet byte-to-word packer with output backpressure. It accepts a byte stream framed by an end-of-packet strobe and emits BYTES-wide words, each with a running byte count, followed by a separate end-of-packet beat. It sits between byte-oriented receivers (MAC/UART/SPI front ends) and word-wide packet buffers or DMA writers. It adds configurable width, lane order and output valid/ready flow control, and flags byte-count overflow.

## Interface
- BYTES, 4: bytes per output word; legal 2..8.
- CW, 12: bytecount width; legal 8..16.
- MSB_FIRST, 0: 0 puts the first byte of a word in lane 0 (bits 7:0); 1 puts it in lane BYTES-1.
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- rxdata  in  8  input byte.
- rxvalid  in  1  rxdata offered.
- rxeop  in  1  end of packet offered; never asserted together with rxvalid.
- rxready  out  1  the offered rxvalid or rxeop is accepted this cycle.
- data  out  8*BYTES  packed word; unfilled lanes are zero.
- bytecount  out  CW  packet bytes accepted up to and including the last byte in data.
- valid  out  1  data beat present.
- eop  out  1  end-of-packet beat present; never asserted together with valid.
- err  out  1  qualified by eop: the packet's byte count exceeded 2^CW-1.
- ready  in  1  consumer accepts the present beat (valid or eop) this cycle.

## Operation
- States: IDLE, FILL, EOP_PEND. A one-entry output slot holds data/bytecount/valid/eop/err until ready.
- IDLE:
  - An accepted rxvalid clears the assembly register, writes the byte to the first lane, sets count=1, sets lane index to 1 (mod BYTES), and moves to FILL.
  - rxeop is accepted and ignored, so empty packets produce no output.
- FILL, accepted byte:
  - The byte is written to lane index; count increments.
  - When lane index wraps to 0, the word moves into the output slot as a data beat and the assembly register clears.
- FILL, accepted rxeop:
  - With a partial word (lane index ≠ 0): that word is loaded as a data beat and the state moves to EOP_PEND.
  - With lane index = 0: an eop beat is loaded directly and the state moves to IDLE.
- EOP_PEND: once the slot frees (empty, or ready high this cycle), an eop beat is loaded and the state moves to IDLE. rxready=0 throughout EOP_PEND.
- rxready:
  - Low in EOP_PEND.
  - Otherwise low only when the offered event would load the slot (completing byte, or eop in FILL) while the slot is occupied and ready=0.
  - The combinational path ready→rxready is permitted.
- Count saturates at 2^CW-1 and sets a sticky overflow bit. err on the eop beat equals the sticky bit, which clears on entry to IDLE. Data beats are still emitted after saturation, carrying the saturated count.
- Lane mapping: lane k occupies bits [8k+7:8k]. The first byte of a word goes to lane 0, or to lane BYTES-1 if MSB_FIRST=1.

## Timing
- Reset: all outputs 0, rxready 0 during reset, state IDLE, count 0, slot empty. Reset mid-packet discards the partial word and any pending beat; no eop is emitted.
- Latency: a data beat is visible the cycle after the completing byte (or rxeop) is accepted. An eop with no partial word is visible the cycle after rxeop is accepted. An eop after a partial word is visible the cycle after that data beat is accepted.
- The slot loads and drains in the same cycle when ready=1, so a full-rate stream of one byte per clock never stalls if ready stays high.
- The beat and all its fields are held stable while valid|eop=1 and ready=0.

## Configuration
- PKT_B2W_KEEP_EN defined: adds output keep (width BYTES). Each bit is 1 for a lane populated by a real byte. A full word is all ones; a partial word has bits set for its populated lanes in MSB_FIRST order. keep is 0 on eop beats and in reset.
- Undefined: no keep port. Consumers derive lanes from bytecount mod BYTES.

## Structure
- pkt_pkg: b2w_state_t enum (IDLE, FILL, EOP_PEND) and the constant PKT_MAX_BYTES=8 used for parameter range checks.
- Sub-module pkt_out_slot: the single-entry valid/ready holding register with load/free signalling. It is reusable by other packet blocks.

## Test plan
- BYTES=4, MSB_FIRST=0, ready=1, bytes 01..06 then eop:
  - 0x04030201/count 4 one cycle after byte 04;
  - 0x00000605/count 6;
  - then eop with err=0.
- BYTES=4, exactly 8 bytes then eop: two data beats with counts 4 and 8, then eop immediately after rxeop with no padded beat.
- MSB_FIRST=1, BYTES=2, bytes AA BB CC, eop: 0xAABB/2, then 0xCC00/3, then eop. With KEEP_EN, keep is 11 then 10.
- ready held 0 for 5 cycles while 8 bytes are offered:
  - rxready drops when the 8th byte would complete the second word;
  - no byte is lost or duplicated;
  - beats are stable while stalled.
- CW=8, a 300-byte packet: count saturates at 255 and eop carries err=1. The next packet's eop carries err=0.
- rst_n low for one cycle mid-word, then bytes 11 22 33 44: a single beat 0x44332211/4, with no stale lanes and no eop from the aborted packet.
